// File: rtl/snake_frame_gen_if.sv
// ---------------------------------------------------------------------------
// snake_frame_gen_if
//
// Pixel read bus between an addressable-LED driver and the snake frame
// generator. The driver announces each new frame, then walks every pixel
// and every colour bit, and the generator returns that single colour bit.
//
//    frame_start  driver -> gen   one-cycle pulse at the start of each frame
//    cnt_pixel    driver -> gen   pixel index being shifted, 0..NPIX-1
//    cnt_bit      driver -> gen   colour bit index being shifted, 0..23
//    pix_bit      gen -> driver   colour bit for (cnt_pixel, cnt_bit)
//
// The returned bit is called pix_bit because "bit" is a reserved word.
// ---------------------------------------------------------------------------
interface snake_frame_gen_if #(
   parameter int IDX_W = 6
) ();

   logic             frame_start;
   logic [IDX_W-1:0] cnt_pixel;
   logic [4:0]       cnt_bit;
   logic             pix_bit;

   // LED driver side
   modport master (
      output frame_start,
      output cnt_pixel,
      output cnt_bit,
      input  pix_bit
   );

   // Frame generator side
   modport slave (
      input  frame_start,
      input  cnt_pixel,
      input  cnt_bit,
      output pix_bit
   );

endinterface

// File: rtl/snake_frame_gen.sv
// ---------------------------------------------------------------------------
// snake_frame_gen
//
// Snake game engine plus frame source for a GRID_W x GRID_H LED matrix.
// The live game state (segment list, length, direction) advances on step
// pulses. At every frame_start a snapshot of that state is taken, and the
// colour bits served to the LED driver come only from the snapshot, so a
// frame is never torn by a move that lands in the middle of it.
//
// Ports
//    sys_clk    rising-edge clock
//    sys_rst_n  asynchronous active-low reset
//    start      one-cycle pulse, begins or restarts a game
//    step       one-cycle pulse, advances the snake one cell
//    ges_data   one-hot direction: 0001 up, 0010 down, 0100 left, 1000 right
//    grow       sampled with step, adds one segment
//    food_idx   food pixel index
//    food_vld   food pixel is valid
//    disp       pixel read bus (frame_start, cnt_pixel, cnt_bit, pix_bit)
//    snake_len  current segment count (live state)
//    head_idx   current head pixel (live state)
//    game_over  high while the game is in OVER
// ---------------------------------------------------------------------------
module snake_frame_gen #(
   parameter int          GRID_W   = 8,
   parameter int          GRID_H   = 8,
   parameter int          MAX_LEN  = 8,
   parameter int          INIT_IDX = 27,
   parameter logic [23:0] HEAD_RGB = 24'h110000,
   parameter logic [23:0] BODY_RGB = 24'h001100,
   parameter logic [23:0] FOOD_RGB = 24'h000011,
   localparam int         NPIX     = GRID_W * GRID_H,
   localparam int         IDX_W    = $clog2(NPIX),
   localparam int         LEN_W    = $clog2(MAX_LEN + 1)
) (
   input  logic               sys_clk,
   input  logic               sys_rst_n,
   input  logic               start,
   input  logic               step,
   input  logic [3:0]         ges_data,
   input  logic               grow,
   input  logic [IDX_W-1:0]   food_idx,
   input  logic               food_vld,
   snake_frame_gen_if.slave   disp,
   output logic [LEN_W-1:0]   snake_len,
   output logic [IDX_W-1:0]   head_idx,
   output logic               game_over
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_OVER
   } state_t;

   // Encoding chosen so that the opposite direction is the code with bit 0
   // flipped, which makes the reversal test a single XOR.
   typedef enum logic [1:0] {
      DIR_UP    = 2'd0,
      DIR_DOWN  = 2'd1,
      DIR_LEFT  = 2'd2,
      DIR_RIGHT = 2'd3
   } dir_t;

   state_t           state;
   dir_t             dir;
   logic [IDX_W-1:0] seg [MAX_LEN];
   logic [LEN_W-1:0] len;

   logic [IDX_W-1:0] disp_seg [MAX_LEN];
   logic [LEN_W-1:0] disp_len;
   logic [IDX_W-1:0] disp_food;
   logic             disp_food_vld;

   logic             ges_ok;
   dir_t             ges_dir;
   logic [IDX_W-1:0] new_head;
   logic             hit;
   logic             pix_bit_c;

   // Decode the gesture into a direction. Anything that is not exactly one
   // hot is ignored, and once the snake has a body a straight reversal is
   // refused because it would drive the head into the first body segment.
   always_comb begin
      ges_ok  = 1'b1;
      ges_dir = dir;
      case (ges_data)
         4'b0001: ges_dir = DIR_UP;
         4'b0010: ges_dir = DIR_DOWN;
         4'b0100: ges_dir = DIR_LEFT;
         4'b1000: ges_dir = DIR_RIGHT;
         default: ges_ok  = 1'b0;
      endcase
      if (ges_ok && (len > LEN_W'(1)) && (ges_dir == dir_t'(dir ^ 2'b01)))
         ges_ok = 1'b0;
   end

   // Candidate head for the next step: split the head index into row and
   // column, move one cell with wrap-around on both axes, then recombine.
   always_comb begin
      int row;
      int col;
      row = int'(seg[0]) / GRID_W;
      col = int'(seg[0]) % GRID_W;
      case (dir)
         DIR_UP:    row = (row == 0) ? GRID_H - 1 : row - 1;
         DIR_DOWN:  row = (row == GRID_H - 1) ? 0 : row + 1;
         DIR_LEFT:  col = (col == 0) ? GRID_W - 1 : col - 1;
         default:   col = (col == GRID_W - 1) ? 0 : col + 1;
      endcase
      new_head = IDX_W'(row * GRID_W + col);
   end

   // Self-collision test against the occupied segments. The tail cell is
   // vacated by the same move unless the snake grows, so it only counts
   // as an obstacle when grow is set.
   always_comb begin
      hit = 1'b0;
      for (int k = 0; k < MAX_LEN; k++) begin
         if ((k < int'(len)) && ((k != int'(len) - 1) || grow) && (seg[k] == new_head))
            hit = 1'b1;
      end
   end

   // Game FSM and live snake state. start has priority over everything
   // else in the same cycle, including a coincident step. On a collision
   // the snake is frozen exactly as it was before the fatal move.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state     <= ST_IDLE;
         dir       <= DIR_RIGHT;
         len       <= LEN_W'(1);
         game_over <= 1'b0;
         for (int k = 0; k < MAX_LEN; k++)
            seg[k] <= (k == 0) ? IDX_W'(INIT_IDX) : '0;
      end else if (start) begin
         state     <= ST_RUN;
         dir       <= DIR_RIGHT;
         len       <= LEN_W'(1);
         game_over <= 1'b0;
         for (int k = 0; k < MAX_LEN; k++)
            seg[k] <= (k == 0) ? IDX_W'(INIT_IDX) : '0;
      end else begin
         if (ges_ok)
            dir <= ges_dir;
         if ((state == ST_RUN) && step) begin
            if (hit) begin
               state     <= ST_OVER;
               game_over <= 1'b1;
            end else begin
               for (int k = MAX_LEN - 1; k > 0; k--)
                  seg[k] <= seg[k-1];
               seg[0] <= new_head;
               if (grow && (int'(len) < MAX_LEN))
                  len <= len + LEN_W'(1);
            end
         end
      end
   end

   // Frame snapshot. Reset clears the length and food flag so the matrix
   // goes dark immediately, even in the middle of a frame.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         disp_len      <= '0;
         disp_food     <= '0;
         disp_food_vld <= 1'b0;
         for (int k = 0; k < MAX_LEN; k++)
            disp_seg[k] <= '0;
      end else if (disp.frame_start) begin
         disp_len      <= len;
         disp_food     <= food_idx;
         disp_food_vld <= food_vld;
         for (int k = 0; k < MAX_LEN; k++)
            disp_seg[k] <= seg[k];
      end
   end

   // Colour lookup for the pixel the driver is shifting, taken only from
   // the snapshot. Head beats body beats food beats black; colour words go
   // out MSB first, and any out-of-range pixel or bit reads as 0.
   always_comb begin
      logic        is_head;
      logic        is_body;
      logic        is_food;
      logic [23:0] colour;
      is_head = (disp_len != '0) && (disp_seg[0] == disp.cnt_pixel);
      is_body = 1'b0;
      for (int k = 1; k < MAX_LEN; k++) begin
         if ((k < int'(disp_len)) && (disp_seg[k] == disp.cnt_pixel))
            is_body = 1'b1;
      end
      is_food = disp_food_vld && (disp_food == disp.cnt_pixel);
      if (is_head)
         colour = HEAD_RGB;
      else if (is_body)
         colour = BODY_RGB;
      else if (is_food)
         colour = FOOD_RGB;
      else
         colour = 24'h000000;
      pix_bit_c = 1'b0;
      if ((int'(disp.cnt_bit) <= 23) && (int'(disp.cnt_pixel) < NPIX))
         pix_bit_c = colour[5'd23 - disp.cnt_bit];
   end

   assign disp.pix_bit = pix_bit_c;
   assign snake_len    = len;
   assign head_idx     = seg[0];

endmodule

// File: doc/snake_frame_gen.md
SNAKE_FRAME_GEN -- requirements
Module: snake_frame_gen

Interface
REQ-001 Parameter GRID_W, default 8, matrix columns.
REQ-002 Parameter GRID_H, default 8, matrix rows; NPIX = GRID_W*GRID_H; IDX_W = clog2(NPIX).
REQ-003 Parameter MAX_LEN, default 8, maximum snake segments.
REQ-004 Parameter INIT_IDX, default 27, head pixel index after reset and after start.
REQ-005 Parameters HEAD_RGB / BODY_RGB / FOOD_RGB, defaults 24'h110000 / 24'h001100 / 24'h000011, 24-bit colour words shifted MSB first.
REQ-006 sys_clk  input  1  single clock, rising edge.
REQ-007 sys_rst_n  input  1  reset; asynchronous assert, active-low.
REQ-008 start  input  1  one-cycle pulse; begins or restarts a game.
REQ-009 step  input  1  one-cycle pulse; advances the snake one cell.
REQ-010 ges_data  input  4  one-hot direction: 0001 up, 0010 down, 0100 left, 1000 right.
REQ-011 grow  input  1  sampled with step; adds one segment.
REQ-012 food_idx / food_vld  input  IDX_W / 1  food pixel and its valid flag.
REQ-013 frame_start  input  1  one-cycle pulse from the LED driver at the start of each frame.
REQ-014 cnt_pixel / cnt_bit  input  IDX_W / 5  pixel index 0..NPIX-1 and bit index 0..23 being shifted.
REQ-015 bit  output  1  colour bit for (cnt_pixel, cnt_bit); combinational from display registers.
REQ-016 snake_len  output  clog2(MAX_LEN+1)  current segment count.
REQ-017 head_idx  output  IDX_W  current head pixel.
REQ-018 game_over  output  1  high while in OVER.

Function
REQ-019 FSM states: IDLE, RUN, OVER; IDLE->RUN on start; RUN->OVER on self-collision; OVER->RUN on start; start in RUN re-initialises the snake and stays in RUN.
REQ-020 Initialisation (reset or start): len=1, seg[0]=INIT_IDX, current direction=right, other seg entries 0.
REQ-021 Index mapping: idx = row*GRID_W + col; row 0 at top.
REQ-022 Direction latch: a valid one-hot ges_data updates the current direction each cycle; non-one-hot values are ignored; a reversal (opposite of current) is ignored when len>1.
REQ-023 On step in RUN: new head = seg[0] moved one cell in the current direction, wrapping col GRID_W-1<->0 and row GRID_H-1<->0.
REQ-024 Move update, same edge: seg[k] <= seg[k-1] for k=1..MAX_LEN-1, seg[0] <= new head.
REQ-025 grow with step: len <= len+1 if len<MAX_LEN; at MAX_LEN, saturate and still move.
REQ-026 Collision: new head equal to any seg[k], k<len, excluding seg[len-1] unless grow is set -> enter OVER with no update to seg or len.
REQ-027 step in IDLE or OVER is ignored; step coincident with start: start wins.
REQ-028 Display snapshot: on frame_start, copy seg[], len, food_idx and food_vld into display registers in one cycle; bit uses only the snapshot, so a move mid-frame never tears the image.
REQ-029 Pixel colour priority: head (disp_seg[0]) > body (disp_seg[1..len-1]) > food (disp_food_vld and idx match) > 24'h000000.
REQ-030 bit = colour[23 - cnt_bit]; cnt_bit>23 or cnt_pixel>=NPIX -> 0.
REQ-031 snake_len, head_idx: registered outputs that track the live (not snapshot) state.

Reset
REQ-032 sys_rst_n low: state=IDLE, init per REQ-020, snapshot len=0 and food_vld=0 (blank frame), game_over=0, snake_len=1, head_idx=INIT_IDX; reset mid-frame blanks immediately.

Verification
REQ-033 Reset, start, frame_start, read pixel 27 bits 0..23 -> 24'h110000; all other pixels 0.
REQ-034 Head at 31 (row3,col7), dir right, step -> head_idx=24; dir up from head 3 -> head_idx=59.
REQ-035 Three steps with grow=1, then step with grow=0 -> snake_len=4, head +4 cols, body pixels BODY_RGB after frame_start.
REQ-036 With len=1, send right->left -> turn accepted; with len=3, left while moving right -> ignored.
REQ-037 Length 5 steered into its own body -> game_over=1, seg frozen; next start -> RUN, len=1, head=INIT_IDX.
REQ-038 step mid-frame without frame_start -> bit stream unchanged until next frame_start; food at 10, food_vld=1 -> pixel 10 = 24'h000011 unless covered by snake.
